plru_tree_array: RTL and testbench
==================================

// Module: plru_tree_array
// PURPOSE
//  Per-set tree pseudo-LRU replacement state for a WAYS-way, SETS-set cache.
//  Holds one (WAYS-1)-bit tree per set. Returns a registered victim way on lookup and updates
//  the tree on every hit or fill access. Sweep-flush FSM re-initialises all sets.
//  Sits beside the tag array; the cache controller drives lookup on miss and access on hit/fill.
// PARAMETERS
//  WAYS   8   associativity; power of 2, >=2
//  SETS   64  number of sets; power of 2, >=2
// PORTS
//  clock          in   1            rising-edge clock
//  reset_n        in   1            reset; asynchronous, active-low
//  lookup_valid   in   1            request victim for lookup_set
//  lookup_set     in   log2(SETS)   set index
//  victim_valid   out  1            victim_way valid (1 cycle after lookup_valid)
//  victim_way     out  log2(WAYS)   chosen victim
//  access_valid   in   1            hit/fill touched access_way in access_set
//  access_set     in   log2(SETS)   set index
//  access_way     in   log2(WAYS)   way touched -> becomes most-recently used
//  flush_req      in   1            pulse: start clearing all trees
//  flush_busy     out  1            flush sweep in progress
//  lock_mask      in   WAYS         [PLRU_LOCK_EN only] 1 = way never chosen
//  victim_none    out  1            [PLRU_LOCK_EN only] all ways locked
// BEHAVIOUR
//  Tree: heap order; node n children 2n+1 / 2n+2; leaves are ways 0..WAYS-1 left to right.
//   Bit 0 = victim in left subtree, 1 = right. Way index MSB = root decision.
//  Victim: walk from root following bits. Access: every node on the path to access_way is
//   set to point AWAY from it; nodes off the path unchanged.
//  Reset (reset_n low, async): all trees = 0; victim_valid=0, victim_way=0, flush_busy=0,
//   victim_none=0; FSM -> IDLE. Reset during a sweep aborts it; trees are already zero.
//  Lookup latency 1 cycle: victim_valid/victim_way registered; victim_valid is a 1-cycle pulse
//   per lookup_valid; back-to-back lookups every cycle supported.
//  Same-cycle lookup and access to the same set: write-first -- victim computed from the
//   post-update tree. Different sets: independent.
//  FSM: IDLE --flush_req--> SWEEP (ptr=0); SWEEP clears tree[ptr] per cycle, ptr++;
//   ptr==SETS-1 -> IDLE. flush_busy=1 exactly SETS cycles, starting the cycle after flush_req.
//   In SWEEP: access ignored, lookup ignored (victim_valid stays 0), flush_req ignored.
//   flush_req with access_valid in IDLE: the access is applied, then the sweep clears it.
//  ptr width log2(SETS); wrap never exercised (terminal compare stops the sweep).
// CONFIGURATION
//  PLRU_LOCK_EN defined: lock_mask/victim_none present. At each node, if every way of the
//   preferred subtree is locked, take the other subtree. All ways locked -> victim_none=1 with
//   victim_valid; victim_way = unlocked-ignoring tree result. lock_mask sampled with lookup.
//   Access updates ignore locks.
//  PLRU_LOCK_EN undefined: ports absent; plain tree walk.
// STRUCTURE
//  Package plru_pkg: typedef plru_fsm_e {PLRU_IDLE, PLRU_SWEEP}; functions
//   plru_victim(tree[, lock]) and plru_update(tree, way) sized by WAYS parameter.
//  One sub-module: plru_tree_logic (combinational victim + update for a single tree),
//   instanced twice (lookup path, access path); the state array stays in plru_tree_array.
// TESTING (WAYS=4, SETS=4 unless noted)
//  1 reset, lookup set0 -> next cycle victim_valid=1, victim_way=0.
//  2 access set0 way0; lookup set0 -> 2; access way2 -> lookup 1; access way1 -> lookup 3;
//    set1 still gives 0.
//  3 same cycle access set2 way0 + lookup set2 -> victim_way=2 (write-first).
//  4 dirty sets 0-3, flush_req -> flush_busy 4 cycles, lookups ignored; after: all victims 0.
//  5 reset_n low mid-sweep (ptr=2) -> flush_busy=0 immediately; lookup set3 -> 0.
//  6 PLRU_LOCK_EN: lock_mask=4'b0011, fresh set -> victim 2; lock_mask=4'b1111 -> victim_none=1.

Source files
------------

// File: rtl/plru_pkg.sv
// Shared types and tree-walk helpers for the per-set pseudo-LRU state.
// The helpers work on a maximum-width tree (up to 64 ways). The caller passes
// the real tree depth, so any power-of-2 associativity up to that width is
// handled by one function body.
package plru_pkg;

  localparam int PLRU_MAX_LEVELS = 6;
  localparam int PLRU_MAX_WAYS   = 1 << PLRU_MAX_LEVELS;

  typedef logic [PLRU_MAX_WAYS-2:0]   plru_tree_t;
  typedef logic [PLRU_MAX_WAYS-1:0]   plru_lock_t;
  typedef logic [PLRU_MAX_LEVELS-1:0] plru_way_t;

  typedef enum logic {
    PLRU_IDLE  = 1'b0,
    PLRU_SWEEP = 1'b1
  } plru_fsm_e;

  // Walk from the root following node bits (0 = left, 1 = right). When at
  // least one way is unlocked, a preferred subtree whose ways are all locked
  // is skipped. With every way locked the locks are ignored entirely.
  function automatic plru_way_t plru_victim(input plru_tree_t tree,
                                            input plru_lock_t lock,
                                            input int         levels);
    int   ways;
    int   prefix;
    int   node;
    int   sub;
    logic dir;
    logic left_lk;
    logic right_lk;
    logic use_lock;
    ways     = 1 << levels;
    use_lock = 1'b0;
    for (int w = 0; w < PLRU_MAX_WAYS; w++) begin
      if (w < ways && !lock[w[5:0]]) use_lock = 1'b1;
    end
    prefix = 0;
    for (int l = 0; l < PLRU_MAX_LEVELS; l++) begin
      if (l < levels) begin
        node     = (1 << l) - 1 + prefix;
        sub      = levels - l - 1;
        left_lk  = 1'b1;
        right_lk = 1'b1;
        for (int w = 0; w < PLRU_MAX_WAYS; w++) begin
          if (w < ways) begin
            if ((w >> sub) == 2 * prefix)     left_lk  = left_lk  & lock[w[5:0]];
            if ((w >> sub) == 2 * prefix + 1) right_lk = right_lk & lock[w[5:0]];
          end
        end
        dir = tree[node[5:0]];
        if (use_lock) begin
          if (!dir && left_lk)      dir = 1'b1;
          else if (dir && right_lk) dir = 1'b0;
        end
        prefix = 2 * prefix + int'(dir);
      end
    end
    return plru_way_t'(prefix);
  endfunction

  // Every node on the root-to-leaf path of 'way' is pointed away from it;
  // nodes off that path keep their value.
  function automatic plru_tree_t plru_update(input plru_tree_t tree,
                                             input plru_way_t  way,
                                             input int         levels);
    plru_tree_t t;
    int         prefix;
    int         node;
    int         wi;
    logic       b;
    t      = tree;
    prefix = 0;
    wi     = int'(way);
    for (int l = 0; l < PLRU_MAX_LEVELS; l++) begin
      if (l < levels) begin
        node             = (1 << l) - 1 + prefix;
        b                = ((wi >> (levels - l - 1)) & 1) != 0;
        t[node[5:0]]     = ~b;
        prefix           = 2 * prefix + int'(b);
      end
    end
    return t;
  endfunction

endpackage

// File: rtl/plru_tree_logic.sv
// Combinational victim selection and MRU update for a single PLRU tree.
module plru_tree_logic
  import plru_pkg::*;
#(
  parameter int WAYS = 8
) (
  input  logic [WAYS-2:0]         tree,
  input  logic [WAYS-1:0]         lock,
  input  logic [$clog2(WAYS)-1:0] way,
  output logic [$clog2(WAYS)-1:0] victim,
  output logic [WAYS-2:0]         tree_next
);

  localparam int LEVELS = $clog2(WAYS);

  plru_tree_t tree_ext;
  plru_lock_t lock_ext;
  plru_way_t  way_ext;

  // Widen to the package maximum, evaluate, then narrow back to this tree.
  always_comb begin
    tree_ext              = '0;
    tree_ext[WAYS-2:0]    = tree;
    lock_ext              = '0;
    lock_ext[WAYS-1:0]    = lock;
    way_ext               = '0;
    way_ext[LEVELS-1:0]   = way;
    victim    = LEVELS'(plru_victim(tree_ext, lock_ext, LEVELS));
    tree_next = (WAYS-1)'(plru_update(tree_ext, way_ext, LEVELS));
  end

endmodule

// File: rtl/plru_tree_array.sv
// Per-set tree pseudo-LRU state for a WAYS-way, SETS-set cache.
// Lookup returns a registered victim one cycle later; access marks a way MRU.
// A flush sweeps every set back to zero, one set per cycle.
// Optional feature macro: PLRU_LOCK_EN adds lock_mask / victim_none so locked
// ways are steered around during the victim walk.
//
// Handshake: lookup_valid and access_valid are single-cycle request strobes
// with no back-pressure; both are accepted only while idle (not sweeping).
// victim_valid pulses for exactly one cycle per accepted lookup. A lookup and
// an access to the same set in one cycle see the post-access tree.
module plru_tree_array
  import plru_pkg::*;
#(
  parameter int WAYS = 8,
  parameter int SETS = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    lookup_valid,
  input  logic [$clog2(SETS)-1:0] lookup_set,
  output logic                    victim_valid,
  output logic [$clog2(WAYS)-1:0] victim_way,
  input  logic                    access_valid,
  input  logic [$clog2(SETS)-1:0] access_set,
  input  logic [$clog2(WAYS)-1:0] access_way,
  input  logic                    flush_req,
  output logic                    flush_busy,
`ifdef PLRU_LOCK_EN
  input  logic [WAYS-1:0]         lock_mask,
  output logic                    victim_none,
`endif
  output logic                    dbg_state
);

  localparam int              SW       = $clog2(SETS);
  localparam int              WW       = $clog2(WAYS);
  localparam logic [SW-1:0]   LAST_SET = SW'(SETS - 1);

  logic [WAYS-2:0] trees [SETS];
  plru_fsm_e       state;
  plru_fsm_e       state_next;
  logic [SW-1:0]   ptr;

  logic            idle;
  logic            lookup_go;
  logic            access_go;
  logic            same_set;
  logic [WAYS-2:0] access_next;
  logic [WAYS-2:0] lookup_tree;
  logic [WAYS-1:0] lock_vec;
  logic [WW-1:0]   lookup_victim;
  logic [WAYS-2:0] lookup_next_unused;
  logic [WW-1:0]   access_victim_unused;

  assign idle       = (state == PLRU_IDLE);
  assign lookup_go  = lookup_valid && idle;
  assign access_go  = access_valid && idle;
  assign same_set   = access_go && (access_set == lookup_set);
  // Write-first: a same-set access in this cycle feeds the lookup walk.
  assign lookup_tree = same_set ? access_next : trees[lookup_set];
  assign flush_busy  = !idle;
  assign dbg_state   = state;

`ifdef PLRU_LOCK_EN
  assign lock_vec = lock_mask;
`else
  assign lock_vec = '0;
`endif

  plru_tree_logic #(.WAYS(WAYS)) u_access_logic (
    .tree      (trees[access_set]),
    .lock      (lock_vec),
    .way       (access_way),
    .victim    (access_victim_unused),
    .tree_next (access_next)
  );

  plru_tree_logic #(.WAYS(WAYS)) u_lookup_logic (
    .tree      (lookup_tree),
    .lock      (lock_vec),
    .way       ('0),
    .victim    (lookup_victim),
    .tree_next (lookup_next_unused)
  );

  // Next-state: a flush request starts a sweep that ends on the last set.
  always_comb begin
    state_next = state;
    case (state)
      PLRU_IDLE:  if (flush_req) state_next = PLRU_SWEEP;
      PLRU_SWEEP: if (ptr == LAST_SET) state_next = PLRU_IDLE;
      default:    state_next = PLRU_IDLE;
    endcase
  end

  // FSM state and sweep pointer; pointer is parked at zero while idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= PLRU_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      if (state == PLRU_SWEEP) ptr <= ptr + SW'(1);
      else                     ptr <= '0;
    end
  end

  // Tree storage: sweep clears one set per cycle, otherwise apply accesses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) trees[s] <= '0;
    end else if (state == PLRU_SWEEP) begin
      trees[ptr] <= '0;
    end else if (access_go) begin
      trees[access_set] <= access_next;
    end
  end

  // Registered victim response, one pulse per accepted lookup.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      victim_valid <= 1'b0;
      victim_way   <= '0;
    end else begin
      victim_valid <= lookup_go;
      if (lookup_go) victim_way <= lookup_victim;
    end
  end

`ifdef PLRU_LOCK_EN
  // All-locked flag accompanies the victim pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) victim_none <= 1'b0;
    else          victim_none <= lookup_go && (&lock_mask);
  end
`endif

endmodule

// File: tb/tb_plru_tree_array.sv
// Directed bench for plru_tree_array (WAYS=4, SETS=4). Expected victims are
// queued when a lookup is driven and compared when victim_valid appears.
module tb_plru_tree_array;

  localparam int WAYS = 4;
  localparam int SETS = 4;
  localparam int SW   = 2;
  localparam int WW   = 2;

  logic          clock;
  logic          reset_n;
  logic          lookup_valid;
  logic [SW-1:0] lookup_set;
  logic          victim_valid;
  logic [WW-1:0] victim_way;
  logic          access_valid;
  logic [SW-1:0] access_set;
  logic [WW-1:0] access_way;
  logic          flush_req;
  logic          flush_busy;
  logic          dbg_state;
`ifdef PLRU_LOCK_EN
  logic [WAYS-1:0] lock_mask;
  logic            victim_none;
`endif

  // Expected entry: {victim_none, victim_way}
  logic [2:0] exp_q[$];
  logic [2:0] mon_e;
  int         n_checks = 0;
  int         n_errors = 0;

  plru_tree_array #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .lookup_valid (lookup_valid),
    .lookup_set   (lookup_set),
    .victim_valid (victim_valid),
    .victim_way   (victim_way),
    .access_valid (access_valid),
    .access_set   (access_set),
    .access_way   (access_way),
    .flush_req    (flush_req),
    .flush_busy   (flush_busy),
`ifdef PLRU_LOCK_EN
    .lock_mask    (lock_mask),
    .victim_none  (victim_none),
`endif
    .dbg_state    (dbg_state)
  );

  // Clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, DUT samples on the rising edge.
  task automatic lookup(input int s, input logic [2:0] exp);
    lookup_valid = 1'b1;
    lookup_set   = SW'(s);
    exp_q.push_back(exp);
    @(negedge clock);
    lookup_valid = 1'b0;
  endtask

  task automatic access(input int s, input int w);
    access_valid = 1'b1;
    access_set   = SW'(s);
    access_way   = WW'(w);
    @(negedge clock);
    access_valid = 1'b0;
  endtask

  task automatic access_and_lookup(input int as, input int aw, input int ls, input logic [2:0] exp);
    access_valid = 1'b1;
    access_set   = SW'(as);
    access_way   = WW'(aw);
    lookup_valid = 1'b1;
    lookup_set   = SW'(ls);
    exp_q.push_back(exp);
    @(negedge clock);
    access_valid = 1'b0;
    lookup_valid = 1'b0;
  endtask

  // Scoreboard: compare each victim pulse against the oldest queued expectation.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && victim_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_victim", 8'(victim_valid), 8'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("victim_way", 8'(victim_way), 8'(mon_e[1:0]));
`ifdef PLRU_LOCK_EN
        check("victim_none", 8'(victim_none), 8'(mon_e[2]));
`endif
      end
    end
  end

  // Directed sequence
  initial begin
    reset_n      = 1'b0;
    lookup_valid = 1'b0;
    lookup_set   = '0;
    access_valid = 1'b0;
    access_set   = '0;
    access_way   = '0;
    flush_req    = 1'b0;
`ifdef PLRU_LOCK_EN
    lock_mask    = '0;
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_victim_valid", 8'(victim_valid), 8'd0);
    check("rst_victim_way",   8'(victim_way),   8'd0);
    check("rst_flush_busy",   8'(flush_busy),   8'd0);
    check("rst_state",        8'(dbg_state),    8'd0);
`ifdef PLRU_LOCK_EN
    check("rst_victim_none",  8'(victim_none),  8'd0);
`endif
    reset_n = 1'b1;
    @(negedge clock);

    // Fresh tree points at way 0
    lookup(0, 3'd0);

    // MRU updates steer the victim around the tree
    access(0, 0);
    lookup(0, 3'd2);
    access(0, 2);
    lookup(0, 3'd1);
    access(0, 1);
    lookup(0, 3'd3);
    lookup(1, 3'd0);

    // Same-cycle access+lookup: same set sees the update, other set does not
    access_and_lookup(2, 0, 2, 3'd2);
    access_and_lookup(3, 0, 1, 3'd0);
    lookup(3, 3'd2);

    // Flush: an access in the request cycle is applied then swept away.
    // During the sweep lookups, a second flush_req and a late access are ignored.
    access(1, 3);
    flush_req    = 1'b1;
    access_valid = 1'b1;
    access_set   = SW'(1);
    access_way   = WW'(3);
    @(negedge clock);
    flush_req    = 1'b0;
    access_valid = 1'b0;
    for (int i = 1; i <= SETS; i++) begin
      check("sweep_busy",      8'(flush_busy),   8'd1);
      check("sweep_no_victim", 8'(victim_valid), 8'd0);
      lookup_valid = 1'b1;
      lookup_set   = SW'(i - 1);
      flush_req    = (i == 2);
      access_valid = (i == SETS);
      access_set   = '0;
      access_way   = WW'(1);
      @(negedge clock);
    end
    lookup_valid = 1'b0;
    access_valid = 1'b0;
    flush_req    = 1'b0;
    check("sweep_done_busy",   8'(flush_busy),   8'd0);
    check("sweep_last_victim", 8'(victim_valid), 8'd0);
    for (int s = 0; s < SETS; s++) lookup(s, 3'd0);

    // Reset in the middle of a sweep (ptr == 2)
    access(3, 0);
    flush_req = 1'b1;
    @(negedge clock);
    flush_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midsweep_rst_busy",  8'(flush_busy), 8'd0);
    check("midsweep_rst_state", 8'(dbg_state),  8'd0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    lookup(3, 3'd0);

`ifdef PLRU_LOCK_EN
    // Locked ways are steered around; all locked falls back to the plain walk
    lock_mask = 4'b0011;
    lookup(1, 3'b0_10);
    lock_mask = 4'b1111;
    lookup(1, 3'b1_00);
    lock_mask = 4'b0000;
    access(2, 0);
    lock_mask = 4'b0100;
    lookup(2, 3'b0_11);
    lock_mask = 4'b0000;
    lookup(2, 3'b0_10);
`endif

    repeat (2) @(negedge clock);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
